stream_unpack: RTL and testbench
================================

Name: stream_unpack

Overview:
- AXI-Stream style width down-converter: accepts one wide word of RATIO lanes and emits the lanes one per beat, lane 0 first.
- Sits on the consumer side of the data route. It breaks the wide words assembled for the systolic array back into narrow words for the narrow output interfaces.
- Two-word internal buffer gives bubble-free narrow output and fully registered ready/valid, with no combinational path between the two interfaces.

Parameters:
- DWIDTH, 32, width of one narrow lane / output beat in bits.
- RATIO, 4, lanes per wide input word (integer >= 1).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- s_in_tdata  input  DWIDTH*RATIO  wide word; lane k = bits [k*DWIDTH +: DWIDTH].
- s_in_tlast  input  1  end-of-packet marker for the wide word.
- s_in_tvalid  input  1  wide word valid.
- s_in_tready  output  1  block can accept a wide word; registered.
- m_out_tdata  output  DWIDTH  current narrow lane.
- m_out_tlast  output  1  high on the last lane of a word whose s_in_tlast was 1.
- m_out_tvalid  output  1  narrow beat valid; registered.
- m_out_tready  input  1  downstream accepts beat.

Behaviour:
- Handshakes:
  - Accept = s_in_tvalid & s_in_tready.
  - Beat = m_out_tvalid & m_out_tready.
  - Retire = Beat & (lane_cnt == RATIO-1).
- Storage: two wide-word slots, each holding data plus its tlast. Head slot is the one being emitted; tail slot is the next word. A pointer bit selects the head; no data is copied between slots.
- lane_cnt: 0..RATIO-1.
  - Increments on Beat.
  - Wraps to 0 on Retire.
  - Held when there is no Beat.
- State machine, based on words stored:
  - EMPTY (0 words):
    - Accept -> ONE.
    - Otherwise stay in EMPTY.
  - ONE (1 word):
    - Accept & ~Retire -> TWO.
    - Retire & ~Accept -> EMPTY.
    - Accept & Retire -> ONE; the new word becomes head.
    - Otherwise stay in ONE.
  - TWO (2 words):
    - Retire -> ONE.
    - Accept cannot occur, because s_in_tready is low.
- Registered outputs:
  - s_in_tready <= (next state != TWO).
  - m_out_tvalid <= (next state != EMPTY).
  - Neither depends combinationally on same-cycle inputs.
- Data output:
  - m_out_tdata = lane[lane_cnt] of the head slot.
  - m_out_tlast = head_last & (lane_cnt == RATIO-1).
  - Both are muxed only from registers and are stable while m_out_tvalid & ~m_out_tready.
- Latency: a word accepted in cycle N presents lane 0 in cycle N+1 when the block was EMPTY.
- Throughput:
  - One narrow beat per cycle, sustained, provided upstream presents a word at least every RATIO cycles.
  - No bubble at word boundaries, since the tail word is already loaded.
- RATIO=1: the block behaves as a 2-deep register slice.
  - Every Beat is a Retire.
  - Full throughput is one word per cycle, with simultaneous Accept & Retire in ONE.
- Backpressure: with m_out_tready low, the output holds and lane_cnt holds. After at most two accepted words, s_in_tready falls.
- Reset:
  - In the cycle after rst is sampled high: state EMPTY, lane_cnt 0, head pointer 0, s_in_tready 0, m_out_tvalid 0.
  - Slot data and tlast are cleared to 0, so m_out_tdata and m_out_tlast are 0.
  - Mid-operation reset discards all buffered words and partial lanes.
  - s_in_tready rises one cycle after rst deasserts.
- No lane-level keep/strobe; every wide word always yields exactly RATIO beats.

Test Plan:
- Single word (DWIDTH=8, RATIO=4, m_out_tready=1): s_in_tdata=0x44332211, tlast=1, accepted at cycle N.
  - Expected: beats 0x11, 0x22, 0x33, 0x44 at cycles N+1..N+4.
  - m_out_tlast only on 0x44; m_out_tvalid low at N+5.
- Back-to-back words 0x44332211 then 0x88776655, second tlast=0, m_out_tready=1.
  - Expected: 8 consecutive beats 0x11..0x88 with no valid gap.
  - m_out_tlast high only on 0x44.
  - s_in_tready low while in TWO.
- Backpressure: m_out_tready=0 for 6 cycles after the first beat is shown, with s_in_tvalid held high.
  - Expected: m_out_tdata stays 0x11; lane_cnt frozen.
  - Exactly two words accepted, then s_in_tready=0.
  - Releasing tready yields the full 8-beat order intact.
- Simultaneous Accept & Retire in ONE (RATIO=1, DWIDTH=8): stream 0x01, 0x02, 0x03 with both sides always ready.
  - Expected: one beat per cycle, 0x01, 0x02, 0x03; s_in_tready stays 1.
- Random ready/valid (RATIO=4, 1000 words, 50% toggling both sides).
  - Expected: output equals the input lanes in order (scoreboard).
  - tlast count equals the input tlast count.
  - No data change while m_out_tvalid & ~m_out_tready.
- Reset mid-word: assert rst after lane 1 of 0xDDCCBBAA is accepted.
  - Expected: next cycle m_out_tvalid=0, s_in_tready=0, m_out_tdata=0.
  - After deassert, a new word 0x44332211 emits 0x11 first (no stale 0xCC).

Source files
------------

// File: rtl/stream_unpack.sv
// stream_unpack: AXI-Stream width down-converter.
// Takes one wide word of RATIO lanes and emits it one narrow lane per beat,
// lane 0 first. A two-slot ping-pong buffer keeps narrow output bubble-free
// and leaves both ready and valid fully registered.
module stream_unpack #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RATIO  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH*RATIO-1:0]  s_in_tdata,
    input  logic                     s_in_tlast,
    input  logic                     s_in_tvalid,
    output logic                     s_in_tready,
    output logic [DWIDTH-1:0]        m_out_tdata,
    output logic                     m_out_tlast,
    output logic                     m_out_tvalid,
    input  logic                     m_out_tready
);

    localparam int unsigned WWIDTH = DWIDTH * RATIO;
    localparam int unsigned CWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CWIDTH-1:0] LAST_LANE = CWIDTH'(RATIO - 1);

    // Occupancy of the two-slot buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WWIDTH-1:0] slot_data [2];
    logic [1:0]        slot_last;
    logic              head_ptr;
    logic [CWIDTH-1:0] lane_cnt;

    logic              accept_c;
    logic              beat_c;
    logic              last_lane_c;
    logic              retire_c;
    logic              wr_ptr_c;
    logic              tready_nxt_c;
    logic              tvalid_nxt_c;
    logic [WWIDTH-1:0] head_data_c;

    // Handshake qualifiers; both sides use only registered ready/valid.
    assign accept_c    = s_in_tvalid & s_in_tready;
    assign beat_c      = m_out_tvalid & m_out_tready;
    assign last_lane_c = (lane_cnt == LAST_LANE);
    assign retire_c    = beat_c & last_lane_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: track the number of words held.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept_c) begin
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept_c && !retire_c) begin
                    state_nxt = TWO;
                end else if (retire_c && !accept_c) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (retire_c) begin
                    state_nxt = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Output/control decode: next ready/valid and the slot a new word lands in.
    always_comb begin
        tready_nxt_c = 1'b0;
        tvalid_nxt_c = 1'b0;
        wr_ptr_c     = head_ptr;
        tready_nxt_c = (state_nxt != TWO);
        tvalid_nxt_c = (state_nxt != EMPTY);
        // An empty buffer loads straight into the head slot; otherwise the
        // new word always goes to the other slot and becomes the tail.
        if (state != EMPTY) begin
            wr_ptr_c = ~head_ptr;
        end
    end

    // Registered handshake outputs, derived from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_in_tready  <= 1'b0;
            m_out_tvalid <= 1'b0;
        end else begin
            s_in_tready  <= tready_nxt_c;
            m_out_tvalid <= tvalid_nxt_c;
        end
    end

    // Slot storage: written in place, never copied between slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot_data[i] <= '0;
            end
            slot_last <= '0;
        end else if (accept_c) begin
            slot_data[wr_ptr_c] <= s_in_tdata;
            slot_last[wr_ptr_c] <= s_in_tlast;
        end
    end

    // Head pointer flips when the head word has emitted its last lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= 1'b0;
        end else if (retire_c) begin
            head_ptr <= ~head_ptr;
        end
    end

    // Lane counter: advances per beat, wraps when the word retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt <= '0;
        end else if (retire_c) begin
            lane_cnt <= '0;
        end else if (beat_c) begin
            lane_cnt <= lane_cnt + CWIDTH'(1);
        end
    end

    assign head_data_c = slot_data[head_ptr];

    // Lane mux from registered head word; stable while the beat is stalled.
    always_comb begin
        m_out_tdata = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (lane_cnt == CWIDTH'(k)) begin
                m_out_tdata = head_data_c[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign m_out_tlast = slot_last[head_ptr] & last_lane_c;

endmodule

// File: tb/tb_stream_unpack.sv
// Self-checking bench for stream_unpack: directed cases plus a randomized
// ready/valid run, checked by per-instance scoreboards.
module tb_stream_unpack;

    localparam int unsigned DW = 8;
    localparam int unsigned RA = 4;
    localparam int unsigned RB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: 4 lanes of 8 bits.
    logic [DW*RA-1:0] a_sdata;
    logic             a_slast, a_svalid, a_sready;
    logic [DW-1:0]    a_mdata;
    logic             a_mlast, a_mvalid, a_mready;

    // Instance B: RATIO=1 register-slice mode.
    logic [DW*RB-1:0] b_sdata;
    logic             b_slast, b_svalid, b_sready;
    logic [DW-1:0]    b_mdata;
    logic             b_mlast, b_mvalid, b_mready;

    stream_unpack #(.DWIDTH(DW), .RATIO(RA)) u_a (
        .clk(clk), .rst(rst),
        .s_in_tdata(a_sdata), .s_in_tlast(a_slast), .s_in_tvalid(a_svalid), .s_in_tready(a_sready),
        .m_out_tdata(a_mdata), .m_out_tlast(a_mlast), .m_out_tvalid(a_mvalid), .m_out_tready(a_mready)
    );

    stream_unpack #(.DWIDTH(DW), .RATIO(RB)) u_b (
        .clk(clk), .rst(rst),
        .s_in_tdata(b_sdata), .s_in_tlast(b_slast), .s_in_tvalid(b_svalid), .s_in_tready(b_sready),
        .m_out_tdata(b_mdata), .m_out_tlast(b_mlast), .m_out_tvalid(b_mvalid), .m_out_tready(b_mready)
    );

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    int errors = 0;
    int checks = 0;
    int a_in_lasts = 0;
    int a_out_lasts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a wide word becomes RATIO narrow beats, lane 0 first,
    // tlast only on the final lane of a word that carried tlast.
    task automatic model_a(input logic [DW*RA-1:0] w, input logic last);
        for (int k = 0; k < int'(RA); k++) begin
            beat_t b;
            b.d = DW'(w >> (k * int'(DW)));
            b.l = last && (k == int'(RA) - 1);
            qa.push_back(b);
        end
    endtask

    // Scoreboard A: push on accept, pop/compare on beat, check stall stability.
    initial begin
        beat_t exp;
        logic  hold_v;
        logic [DW:0] hold;
        hold_v = 1'b0;
        hold   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                qa.delete();
                hold_v = 1'b0;
            end else begin
                if (a_svalid && a_sready) begin
                    model_a(a_sdata, a_slast);
                    if (a_slast) a_in_lasts++;
                end
                if (hold_v) chk("a_stall_hold", {a_mvalid, a_mlast, a_mdata}, {1'b1, hold});
                if (a_mvalid && a_mready) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected_beat: data %0h with empty scoreboard at %0t", a_mdata, $time);
                    end else begin
                        exp = qa.pop_front();
                        chk("a_beat", {a_mlast, a_mdata}, {exp.l, exp.d});
                    end
                    if (a_mlast) a_out_lasts++;
                end
                hold_v = a_mvalid && !a_mready;
                hold   = {a_mlast, a_mdata};
            end
        end
    end

    // Scoreboard B: RATIO=1, each word is exactly one beat.
    initial begin
        beat_t exp;
        beat_t nb;
        forever begin
            @(negedge clk);
            if (rst) begin
                qb.delete();
            end else begin
                if (b_svalid && b_sready) begin
                    nb.d = b_sdata;
                    nb.l = b_slast;
                    qb.push_back(nb);
                end
                if (b_mvalid && b_mready) begin
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected_beat: data %0h with empty scoreboard at %0t", b_mdata, $time);
                    end else begin
                        exp = qb.pop_front();
                        chk("b_beat", {b_mlast, b_mdata}, {exp.l, exp.d});
                    end
                end
            end
        end
    end

    // Hard stop if anything hangs.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic drain_a();
        int n;
        n = 0;
        a_mready = 1'b1;
        while ((qa.size() != 0 || a_mvalid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("a_drain_empty", qa.size(), 0);
    endtask

    initial begin
        logic [31:0] wv [3];
        int          nacc;
        logic        acc;
        int          in0;
        int          out0;
        int          waitc;

        rst = 1'b1;
        a_sdata = '0; a_slast = 1'b0; a_svalid = 1'b0; a_mready = 1'b0;
        b_sdata = '0; b_slast = 1'b0; b_svalid = 1'b0; b_mready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_sready", a_sready, 0);
        chk("rst_a_mvalid", a_mvalid, 0);
        chk("rst_a_mdata", a_mdata, 0);
        chk("rst_a_mlast", a_mlast, 0);
        chk("rst_b_sready", b_sready, 0);
        chk("rst_b_mvalid", b_mvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_sready_low", a_sready, 0);
        @(posedge clk); #1;
        chk("rst_rel_sready_high", a_sready, 1);

        // Single word, latency and tlast placement.
        a_mready = 1'b1;
        a_svalid = 1'b1; a_sdata = 32'h44332211; a_slast = 1'b1;
        @(posedge clk); #1;
        a_svalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_valid", a_mvalid, 1);
            chk("single_data", a_mdata, 8'(8'h11 * (k + 1)));
            chk("single_last", a_mlast, (k == 3));
        end
        @(negedge clk);
        chk("single_valid_after", a_mvalid, 0);

        // Back-to-back words: eight gapless beats, ready low while two held.
        @(posedge clk); #1;
        a_svalid = 1'b1; a_sdata = 32'h44332211; a_slast = 1'b1;
        @(posedge clk); #1;
        a_sdata = 32'h88776655; a_slast = 1'b0;
        @(negedge clk);
        chk("b2b_data0", a_mdata, 8'h11);
        chk("b2b_sready_one", a_sready, 1);
        @(posedge clk); #1;
        a_svalid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("b2b_valid", a_mvalid, 1);
            chk("b2b_data", a_mdata, 8'(8'h11 * (k + 1)));
            chk("b2b_last", a_mlast, (k == 3));
            if (k <= 3) chk("b2b_sready_two", a_sready, 0);
        end
        @(negedge clk);
        chk("b2b_valid_after", a_mvalid, 0);

        // Backpressure: output frozen, exactly two words taken.
        @(posedge clk); #1;
        wv[0] = 32'h44332211; wv[1] = 32'h88776655; wv[2] = 32'hCCBBAA99;
        a_mready = 1'b0;
        nacc = 0;
        a_svalid = 1'b1; a_sdata = wv[0]; a_slast = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = a_sready;
            if (c >= 1) begin
                chk("bp_hold_valid", a_mvalid, 1);
                chk("bp_hold_data", a_mdata, 8'h11);
            end
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                a_sdata = wv[nacc];
                a_slast = 1'b0;
            end
        end
        chk("bp_accept_count", nacc, 2);
        chk("bp_sready_low", a_sready, 0);
        a_svalid = 1'b0;
        a_mready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("bp_rel_valid", a_mvalid, 1);
            chk("bp_rel_data", a_mdata, 8'(8'h11 * (k + 1)));
            chk("bp_rel_last", a_mlast, (k == 3));
        end
        @(negedge clk);
        chk("bp_rel_valid_after", a_mvalid, 0);

        // RATIO=1: accept and retire in the same cycle.
        @(posedge clk); #1;
        b_mready = 1'b1;
        b_svalid = 1'b1; b_sdata = 8'h01; b_slast = 1'b0;
        @(posedge clk); #1;
        b_sdata = 8'h02;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("r1_valid", b_mvalid, 1);
            chk("r1_data", b_mdata, k);
            chk("r1_sready", b_sready, 1);
            @(posedge clk); #1;
            if (k == 1) begin
                b_sdata = 8'h03; b_slast = 1'b1;
            end else begin
                b_svalid = 1'b0;
            end
        end
        @(negedge clk);
        chk("r1_valid_after", b_mvalid, 0);

        // Randomized ready/valid on both sides.
        @(posedge clk); #1;
        in0  = a_in_lasts;
        out0 = a_out_lasts;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                a_svalid = 1'b0;
                @(posedge clk); #1;
                a_mready = 1'($urandom_range(0, 1));
            end
            a_svalid = 1'b1;
            a_sdata  = $urandom;
            a_slast  = ($urandom_range(0, 3) == 0);
            acc   = 1'b0;
            waitc = 0;
            while (!acc && waitc < 200) begin
                @(negedge clk);
                acc = a_sready;
                @(posedge clk); #1;
                a_mready = 1'($urandom_range(0, 1));
                waitc++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL rand_accept_timeout: word %0d not accepted in %0d cycles", i, waitc);
                break;
            end
        end
        a_svalid = 1'b0;
        drain_a();
        chk("rand_tlast_count", a_out_lasts - out0, a_in_lasts - in0);

        // Mid-word reset discards the partial word.
        a_mready = 1'b1;
        a_svalid = 1'b1; a_sdata = 32'hDDCCBBAA; a_slast = 1'b0;
        @(posedge clk); #1;
        a_svalid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_mvalid", a_mvalid, 0);
        chk("mrst_sready", a_sready, 0);
        chk("mrst_mdata", a_mdata, 0);
        chk("mrst_mlast", a_mlast, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_svalid = 1'b1; a_sdata = 32'h44332211; a_slast = 1'b1;
        @(negedge clk);
        chk("mrst_sready_still_low", a_sready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_sready_up", a_sready, 1);
        chk("mrst_mvalid_idle", a_mvalid, 0);
        @(posedge clk); #1;
        a_svalid = 1'b0;
        @(negedge clk);
        chk("mrst_first_valid", a_mvalid, 1);
        chk("mrst_first_data", a_mdata, 8'h11);
        @(posedge clk); #1;
        drain_a();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
